// File: rtl/cpu_mcycle_seq_pkg.sv
// Shared types and constants for the SM83 M-cycle/T-state sequencer.
package cpu_seq_pkg;

  // Width of the M-cycle index (M1..M6 -> 0..5)
  localparam int MCYC_W = 3;

  // One-hot T-state encoding, T1 in bit 0
  typedef logic [3:0] tstate_t;
  localparam tstate_t T1 = 4'b0001;
  localparam tstate_t T2 = 4'b0010;
  localparam tstate_t T3 = 4'b0100;
  localparam tstate_t T4 = 4'b1000;

  // Address source for the bus interface
  typedef enum logic [1:0] {
    ADR_PC = 2'b00,
    ADR_HL = 2'b01,
    ADR_SP = 2'b10,
    ADR_WZ = 2'b11
  } adr_sel_t;

  // Run/halt control state
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_st_t;

endpackage

// File: rtl/cpu_mcycle_seq_if.sv
// Decoder hints in, bus strobes and sequencing status out.
// master = sequencer side, slave = decoder/bus side.
interface cpu_mcycle_seq_if;
  import cpu_seq_pkg::*;

  logic              ce;
  logic              dec_mcyc_last;
  logic              dec_bus_rd;
  logic              dec_bus_wr;
  adr_sel_t          dec_adr_sel;
  logic              halt_req;
  logic              wake;

  tstate_t           t_state;
  logic [MCYC_W-1:0] m_cycle;
  logic              m1;
  adr_sel_t          adr_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic              ir_load;
  logic              pc_inc;
  logic              reg_we;
  logic              instr_done;
  logic              halted;
  logic              seq_err;

  modport master (
    input  ce, dec_mcyc_last, dec_bus_rd, dec_bus_wr, dec_adr_sel, halt_req, wake,
    output t_state, m_cycle, m1, adr_sel, mem_rd, mem_wr, ir_load, pc_inc,
           reg_we, instr_done, halted, seq_err
  );

  modport slave (
    output ce, dec_mcyc_last, dec_bus_rd, dec_bus_wr, dec_adr_sel, halt_req, wake,
    input  t_state, m_cycle, m1, adr_sel, mem_rd, mem_wr, ir_load, pc_inc,
           reg_we, instr_done, halted, seq_err
  );

endinterface

// File: rtl/cpu_mcycle_seq_tstate_ctr.sv
// One-hot T1..T4 ring counter, advancing only on ce.
module cpu_tstate_ctr
  import cpu_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_ce,
  output tstate_t o_t_state,
  output logic    o_t4_ce
);

  tstate_t r_t_state;

  // Rotate the one-hot T state left on each enabled clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t_state <= T1;
    end else if (i_ce) begin
      r_t_state <= {r_t_state[2:0], r_t_state[3]};
    end
  end

  assign o_t_state = r_t_state;
  // Single-clock strobe marking the end of the current machine cycle
  assign o_t4_ce   = r_t_state[3] & i_ce;

endmodule

// File: rtl/cpu_mcycle_seq.sv
// SM83 M-cycle/T-state sequencer: M counter, HALT control and strobe decode.
module cpu_mcycle_seq #(
  parameter int MCYC_MAX = 6
) (
  input  logic             clk,
  input  logic             reset,
  cpu_mcycle_seq_if.master bus
);
  import cpu_seq_pkg::*;

  localparam logic [MCYC_W-1:0] M_LAST = MCYC_W'(MCYC_MAX - 1);

  tstate_t           w_t_state;
  logic              w_t4_ce;
  halt_st_t          r_state;
  halt_st_t          w_state_next;
  logic [MCYC_W-1:0] r_m_cycle;
  logic [MCYC_W-1:0] w_m_next;
  logic              r_seq_err;
  logic              w_err_next;

  logic              w_run;
  logic              w_m1;
  logic              w_t12;
  logic              w_t23;
  adr_sel_t          w_adr_sel;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic              w_ir_load;
  logic              w_pc_inc;
  logic              w_reg_we;
  logic              w_instr_done;

  cpu_tstate_ctr u_tstate (
    .clk       (clk),
    .rst       (reset),
    .i_ce      (bus.ce),
    .o_t_state (w_t_state),
    .o_t4_ce   (w_t4_ce)
  );

  // Sequencer state register: run/halt, M index and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_m_cycle <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_m_cycle <= w_m_next;
      r_seq_err <= w_err_next;
    end
  end

  // Next-state: M-cycle stepping, overflow recovery and HALT entry/exit, all at T4
  always_comb begin
    w_state_next = r_state;
    w_m_next     = r_m_cycle;
    w_err_next   = r_seq_err;
    if (w_t4_ce) begin
      if (r_state == ST_HALT) begin
        // M index is already 0 while halted; only a wake can leave
        if (bus.wake) begin
          w_state_next = ST_RUN;
        end
      end else if (bus.dec_mcyc_last) begin
        w_m_next = '0;
        // A pending interrupt at the same T4 cancels the HALT
        if (bus.halt_req && !bus.wake) begin
          w_state_next = ST_HALT;
        end
      end else if (r_m_cycle == M_LAST) begin
        // Runaway instruction: restart at M1 and flag it
        w_m_next   = '0;
        w_err_next = 1'b1;
      end else begin
        w_m_next = r_m_cycle + MCYC_W'(1);
      end
    end
  end

  assign w_run = (r_state == ST_RUN);
  assign w_m1  = (r_m_cycle == '0);
  assign w_t12 = w_t_state[0] | w_t_state[1];
  assign w_t23 = w_t_state[1] | w_t_state[2];

  // Strobe decode; reset forces every strobe low without waiting for a clock
  always_comb begin
    w_adr_sel    = ADR_PC;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_reg_we     = 1'b0;
    w_instr_done = 1'b0;
    if (!reset && w_run) begin
      if (w_m1) begin
        w_mem_rd  = w_t12;
        w_ir_load = w_t_state[2] & bus.ce;
        w_pc_inc  = w_t_state[2] & bus.ce;
      end else begin
        w_adr_sel = bus.dec_adr_sel;
        w_mem_rd  = w_t12 & bus.dec_bus_rd;
        // Read wins when the decoder asks for both
        w_mem_wr  = w_t23 & bus.dec_bus_wr & !bus.dec_bus_rd;
      end
      w_reg_we     = w_t4_ce & bus.dec_mcyc_last;
      w_instr_done = w_t4_ce & bus.dec_mcyc_last;
    end
  end

  assign bus.t_state    = w_t_state;
  assign bus.m_cycle    = r_m_cycle;
  assign bus.m1         = w_m1;
  assign bus.adr_sel    = w_adr_sel;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.ir_load    = w_ir_load;
  assign bus.pc_inc     = w_pc_inc;
  assign bus.reg_we     = w_reg_we;
  assign bus.instr_done = w_instr_done;
  assign bus.halted     = (r_state == ST_HALT);
  assign bus.seq_err    = r_seq_err;

endmodule

// File: tb/tb_cpu_mcycle_seq.sv
// Bench for cpu_mcycle_seq: constant vector table, directed corner sequences,
// and randomized traffic against an integer-level behavioural model.
module tb_cpu_mcycle_seq;
  import cpu_seq_pkg::*;

  localparam int MCYC_MAX = 6;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   miscompares;

  // Behavioural model state: T index 0..3, M index, halted, sticky error
  int   mt;
  int   mm;
  bit   mh;
  bit   me;

  cpu_mcycle_seq_if intf ();

  cpu_mcycle_seq #(.MCYC_MAX(MCYC_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle from plain fields
  function automatic logic [18:0] e(int t, int m, logic [1:0] adr, bit rd, bit wr,
                                    bit ir, bit pc, bit we, bit dn, bit h, bit er);
    logic [3:0] th;
    th = 4'(1 << t);
    return {th, 3'(m), (m == 0), adr, rd, wr, ir, pc, we, dn, h, er};
  endfunction

  function automatic logic [18:0] act_out();
    return {intf.t_state, intf.m_cycle, intf.m1, intf.adr_sel, intf.mem_rd, intf.mem_wr,
            intf.ir_load, intf.pc_inc, intf.reg_we, intf.instr_done, intf.halted,
            intf.seq_err};
  endfunction

  // Reference behaviour of the outputs for the current model state and inputs
  function automatic logic [18:0] model_exp(bit c, bit l, bit r, bit w, logic [1:0] a);
    if (reset)
      return e(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (mh)
      return e(mt, mm, 2'd0, 0, 0, 0, 0, 0, 0, 1, me);
    if (mm == 0)
      return e(mt, mm, 2'd0, mt < 2, 0, (mt == 2) && c, (mt == 2) && c,
               (mt == 3) && c && l, (mt == 3) && c && l, 0, me);
    return e(mt, mm, a, r && (mt < 2), w && !r && (mt == 1 || mt == 2), 0, 0,
             (mt == 3) && c && l, (mt == 3) && c && l, 0, me);
  endfunction

  task automatic model_adv(bit c, bit l, bit hr, bit wk);
    if (!c) return;
    if (mt == 3) begin
      if (mh) begin
        if (wk) mh = 0;
      end else if (l) begin
        mm = 0;
        if (hr && !wk) mh = 1;
      end else if (mm == MCYC_MAX - 1) begin
        mm = 0;
        me = 1;
      end else begin
        mm = mm + 1;
      end
    end
    mt = (mt + 1) % 4;
  endtask

  task automatic check(string nm, logic [18:0] act, logic [18:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end else begin
      $display("vec %0d %s out=%b ok", vec_cnt, nm, act);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end else begin
      $display("vec %0d %s val=%b ok", vec_cnt, nm, act);
    end
  endtask

  task automatic drive(bit c, bit l, bit r, bit w, logic [1:0] a, bit hr, bit wk);
    intf.ce            = c;
    intf.dec_mcyc_last = l;
    intf.dec_bus_rd    = r;
    intf.dec_bus_wr    = w;
    intf.dec_adr_sel   = adr_sel_t'(a);
    intf.halt_req      = hr;
    intf.wake          = wk;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model on posedge
  task automatic step(string nm, bit c, bit l, bit r, bit w, logic [1:0] a, bit hr, bit wk);
    drive(c, l, r, w, a, hr, wk);
    #4;
    check(nm, act_out(), model_exp(c, l, r, w, a));
    @(posedge clk);
    model_adv(c, l, hr, wk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mt = 0; mm = 0; mh = 0; me = 0;
    drive(0, 0, 0, 0, 2'd0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  in;   // {ce, last, rd, wr, adr[1:0], halt_req, wake}
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    vec_cnt     = 0;
    miscompares = 0;
    reset       = 1'b1;

    // 1-M instruction followed by a 3-M instruction (rd HL, then wr SP)
    tbl[0]  = '{8'b11000000, e(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{8'b11000000, e(1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{8'b11000000, e(2, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[3]  = '{8'b11000000, e(3, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[4]  = '{8'b10000000, e(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{8'b10000000, e(1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{8'b10000000, e(2, 0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0)};
    tbl[7]  = '{8'b10000000, e(3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{8'b10100100, e(0, 1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{8'b10100100, e(1, 1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{8'b10100100, e(2, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{8'b10100100, e(3, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{8'b11011000, e(0, 2, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{8'b11011000, e(1, 2, 2'd2, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{8'b11011000, e(2, 2, 2'd2, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{8'b11011000, e(3, 2, 2'd2, 0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[16] = '{8'b11001000, e(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0)};

    // Reset state, observed while reset is still asserted
    drive(0, 0, 0, 0, 2'd0, 0, 0);
    #2;
    check("reset_state", act_out(), e(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    // Constant table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].in[7], tbl[i].in[6], tbl[i].in[5], tbl[i].in[4], tbl[i].in[3:2],
            tbl[i].in[1], tbl[i].in[0]);
      #4;
      check($sformatf("table_%0d", i), act_out(), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset asserted at M2 T3 while a write strobe is active
    do_reset();
    for (int k = 0; k < 4; k++) step("mid_m1", 1, 0, 0, 0, 2'd0, 0, 0);
    for (int k = 0; k < 2; k++) step("mid_m2", 1, 0, 0, 1, 2'd2, 0, 0);
    drive(1, 0, 0, 1, 2'd2, 0, 0);
    #2;
    chk1("m2t3_mem_wr", intf.mem_wr, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset", act_out(), e(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    // ce pattern 1,0,0 repeated: each T state held while ce is low
    for (int k = 0; k < 18; k++) step("ce_gap", (k % 3) == 0, 1, 0, 0, 2'd0, 0, 0);

    // HALT entry, three halted M-cycles, then wake
    do_reset();
    for (int k = 0; k < 4; k++) step("halt_entry", 1, 1, 0, 0, 2'd0, 1, 0);
    chk1("halted_set", intf.halted, 1'b1);
    for (int k = 0; k < 12; k++) step("halted", 1, 1, 1, 0, 2'd1, 0, 0);
    chk1("still_halted", intf.halted, 1'b1);
    for (int k = 0; k < 4; k++) step("wake", 1, 1, 0, 0, 2'd0, 0, 1);
    chk1("halted_clear", intf.halted, 1'b0);
    for (int k = 0; k < 4; k++) step("post_wake", 1, 1, 0, 0, 2'd0, 0, 0);

    // halt_req and wake together: HALT not entered
    for (int k = 0; k < 4; k++) step("halt_wake", 1, 1, 0, 0, 2'd0, 1, 1);
    chk1("no_halt", intf.halted, 1'b0);

    // Runaway instruction: six non-last M-cycles
    do_reset();
    for (int k = 0; k < 24; k++) step("overrun", 1, 0, 1, 1, 2'd3, 0, 0);
    chk1("seq_err_set", intf.seq_err, 1'b1);
    chk1("m_cycle_wrap", intf.m_cycle == '0, 1'b1);
    for (int k = 0; k < 8; k++) step("err_sticky", 1, 1, 0, 0, 2'd0, 0, 0);

    // Randomized traffic with periodic resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 600) == 599) begin
        do_reset();
      end else begin
        step("rand",
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
